// File: rtl/hwpe_stream_ready_cut.sv
// hwpe_stream_ready_cut
//   Two-entry skid buffer that cuts both the forward (valid/data/strb) and the
//   backward (ready) paths of an hwpe_stream link. It sustains one beat per
//   cycle and adds one cycle of latency. push_ready and pop_valid are decoded
//   from the state register only, so no combinational path runs from pop_ready
//   to push_ready or from push_valid to pop_valid.
//
// Ports
//   clk_i        in   1             clock, rising edge
//   rst_i        in   1             asynchronous active-high reset
//   clear_i      in   1             synchronous clear; flushes stored beats and
//                                   discards any beat pushed in the same cycle
//   push_valid   in   1             upstream beat valid
//   push_data    in   DATA_WIDTH    upstream data
//   push_strb    in   DATA_WIDTH/8  upstream byte strobe
//   push_ready   out  1             upstream ready (state decode only)
//   pop_valid    out  1             downstream valid (state decode only)
//   pop_data     out  DATA_WIDTH    downstream data, straight from out_q
//   pop_strb     out  DATA_WIDTH/8  downstream strobe, straight from out_q
//   pop_ready    in   1             downstream ready
//   occupancy_o  out  2             entries held: 0, 1 or 2
module hwpe_stream_ready_cut #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    push_valid,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic [DATA_WIDTH/8-1:0] push_strb,
  output logic                    push_ready,
  output logic                    pop_valid,
  output logic [DATA_WIDTH-1:0]   pop_data,
  output logic [DATA_WIDTH/8-1:0] pop_strb,
  input  logic                    pop_ready,
  output logic [1:0]              occupancy_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   out_data_q, skid_data_q;
  logic [STRB_WIDTH-1:0]   out_strb_q, skid_strb_q;

  logic push_hs;
  logic pop_hs;
  logic out_load_push;
  logic out_load_skid;
  logic skid_load;

  // Output and ready decode: depends on state_q only.
  always_comb begin
    push_ready  = 1'b1;
    pop_valid   = 1'b0;
    occupancy_o = 2'd0;
    case (state_q)
      ONE: begin
        pop_valid   = 1'b1;
        occupancy_o = 2'd1;
      end
      TWO: begin
        pop_valid   = 1'b1;
        push_ready  = 1'b0;
        occupancy_o = 2'd2;
      end
      default: ;
    endcase
  end

  assign push_hs = push_valid & push_ready;
  assign pop_hs  = pop_valid & pop_ready;

  // Next state and storage enables.
  always_comb begin
    state_d       = state_q;
    out_load_push = 1'b0;
    out_load_skid = 1'b0;
    skid_load     = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push_hs) begin
          state_d       = ONE;
          out_load_push = 1'b1;
        end
      end
      ONE: begin
        if (push_hs && pop_hs) begin
          out_load_push = 1'b1;
        end else if (push_hs) begin
          state_d   = TWO;
          skid_load = 1'b1;
        end else if (pop_hs) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // push_ready is low here, so only a pop can move the state.
        if (pop_hs) begin
          state_d       = ONE;
          out_load_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (clear_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_data_q <= '0;
      out_strb_q <= '0;
    end else if (clear_i) begin
      out_data_q <= '0;
      out_strb_q <= '0;
    end else if (out_load_push) begin
      out_data_q <= push_data;
      out_strb_q <= push_strb;
    end else if (out_load_skid) begin
      out_data_q <= skid_data_q;
      out_strb_q <= skid_strb_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_data_q <= '0;
      skid_strb_q <= '0;
    end else if (clear_i) begin
      skid_data_q <= '0;
      skid_strb_q <= '0;
    end else if (skid_load) begin
      skid_data_q <= push_data;
      skid_strb_q <= push_strb;
    end
  end

  assign pop_data = out_data_q;
  assign pop_strb = out_strb_q;

endmodule

// File: tb/tb_hwpe_stream_ready_cut.sv
// Testbench for hwpe_stream_ready_cut (DATA_WIDTH=64): directed table vectors,
// hand-written reset/streaming sequences and a randomized run against a
// queue-based reference model of a 2-deep FIFO with registered outputs.
module tb_hwpe_stream_ready_cut;

  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          clear_i = 1'b0;
  logic          push_valid = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic [SW-1:0] push_strb = '0;
  logic          push_ready;
  logic          pop_valid;
  logic [DW-1:0] pop_data;
  logic [SW-1:0] pop_strb;
  logic          pop_ready = 1'b0;
  logic [1:0]    occupancy_o;

  int checks = 0;
  int errors = 0;

  hwpe_stream_ready_cut #(.DATA_WIDTH(DW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .push_valid  (push_valid),
    .push_data   (push_data),
    .push_strb   (push_strb),
    .push_ready  (push_ready),
    .pop_valid   (pop_valid),
    .pop_data    (pop_data),
    .pop_strb    (pop_strb),
    .pop_ready   (pop_ready),
    .occupancy_o (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: FIFO of at most two {data,strb} beats.
  logic [DW+SW-1:0] mq[$];
  logic             zk = 1'b1;  // output storage known to be zero

  function automatic void chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endfunction

  task automatic tick();
    logic phs, pps;
    phs = push_valid && (mq.size() < 2);
    pps = (mq.size() > 0) && pop_ready;
    @(posedge clk_i);
    if (clear_i) begin
      mq.delete();
      zk = 1'b1;
    end else begin
      if (pps) void'(mq.pop_front());
      if (phs) begin
        mq.push_back({push_data, push_strb});
        zk = 1'b0;
      end
    end
    #1;
  endtask

  task automatic check_model(string tag);
    chk({tag, "_valid"}, 64'(pop_valid), 64'(mq.size() > 0));
    chk({tag, "_ready"}, 64'(push_ready), 64'(mq.size() < 2));
    chk({tag, "_occ"}, 64'(occupancy_o), 64'(mq.size()));
    if (mq.size() > 0) begin
      chk({tag, "_data"}, pop_data, mq[0][DW+SW-1:SW]);
      chk({tag, "_strb"}, 64'(pop_strb), 64'(mq[0][SW-1:0]));
    end else if (zk) begin
      chk({tag, "_data0"}, pop_data, 64'd0);
      chk({tag, "_strb0"}, 64'(pop_strb), 64'd0);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_valid"}, 64'(pop_valid), 64'd0);
    chk({tag, "_ready"}, 64'(push_ready), 64'd1);
    chk({tag, "_occ"}, 64'(occupancy_o), 64'd0);
    chk({tag, "_data"}, pop_data, 64'd0);
    chk({tag, "_strb"}, 64'(pop_strb), 64'd0);
  endtask

  task automatic do_reset();
    push_valid = 1'b0;
    clear_i    = 1'b0;
    pop_ready  = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("reset");
    #2;
    rst_i = 1'b0;
    mq.delete();
    zk = 1'b1;
  endtask

  typedef struct {
    logic          pv;
    logic [DW-1:0] pd;
    logic [SW-1:0] ps;
    logic          pr;
    logic          clr;
    logic          ev;
    logic          er;
    logic [1:0]    eo;
    logic          cd;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
  } vec_t;

  function automatic vec_t mk(logic pv, logic [DW-1:0] pd, logic [SW-1:0] ps,
                              logic pr, logic clr, logic ev, logic er,
                              logic [1:0] eo, logic cd, logic [DW-1:0] ed,
                              logic [SW-1:0] es);
    vec_t v;
    v.pv = pv; v.pd = pd; v.ps = ps; v.pr = pr; v.clr = clr;
    v.ev = ev; v.er = er; v.eo = eo; v.cd = cd; v.ed = ed; v.es = es;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    int pushed;
    int cyc;
    logic phs;

    // Inputs applied before the edge; expected outputs after it.
    // Backpressure: A,B fill both entries, C is refused, then drain.
    vt.push_back(mk(1, 64'hA, 8'h0F, 0, 0, 1, 1, 2'd1, 1, 64'hA, 8'h0F));
    vt.push_back(mk(1, 64'hB, 8'hF0, 0, 0, 1, 0, 2'd2, 1, 64'hA, 8'h0F));
    vt.push_back(mk(1, 64'hC, 8'h0F, 0, 0, 1, 0, 2'd2, 1, 64'hA, 8'h0F));
    vt.push_back(mk(0, 64'h0, 8'h00, 1, 0, 1, 1, 2'd1, 1, 64'hB, 8'hF0));
    vt.push_back(mk(0, 64'h0, 8'h00, 1, 0, 0, 1, 2'd0, 0, 64'h0, 8'h00));
    // Clear in TWO with push_valid high: everything flushed, beat 3 lost.
    vt.push_back(mk(1, 64'h1, 8'hFF, 0, 0, 1, 1, 2'd1, 1, 64'h1, 8'hFF));
    vt.push_back(mk(1, 64'h2, 8'h0F, 0, 0, 1, 0, 2'd2, 1, 64'h1, 8'hFF));
    vt.push_back(mk(1, 64'h3, 8'hF0, 1, 1, 0, 1, 2'd0, 1, 64'h0, 8'h00));
    vt.push_back(mk(0, 64'h0, 8'h00, 1, 0, 0, 1, 2'd0, 1, 64'h0, 8'h00));
    vt.push_back(mk(1, 64'h4, 8'h3C, 0, 0, 1, 1, 2'd1, 1, 64'h4, 8'h3C));
    vt.push_back(mk(0, 64'h0, 8'h00, 1, 0, 0, 1, 2'd0, 0, 64'h0, 8'h00));
    // Clear in ONE overrides a simultaneous push and pop handshake.
    vt.push_back(mk(1, 64'h5, 8'h11, 0, 0, 1, 1, 2'd1, 1, 64'h5, 8'h11));
    vt.push_back(mk(1, 64'h6, 8'h22, 1, 1, 0, 1, 2'd0, 1, 64'h0, 8'h00));
    vt.push_back(mk(0, 64'h0, 8'h00, 1, 0, 0, 1, 2'd0, 1, 64'h0, 8'h00));

    #1;
    do_reset();

    // Reset while holding two beats: outputs return to idle immediately.
    push_valid = 1'b1; push_data = 64'h11; push_strb = 8'h0F; pop_ready = 1'b0;
    tick();
    push_data = 64'h22; push_strb = 8'hF0;
    tick();
    chk("pre_rst_occ", 64'(occupancy_o), 64'd2);
    push_valid = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    #1;
    rst_i = 1'b0;
    mq.delete();
    zk = 1'b1;
    pop_ready = 1'b1;
    tick();
    check_reset_outputs("post_rst");

    // Table vectors.
    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      push_valid = vt[i].pv;
      push_data  = vt[i].pd;
      push_strb  = vt[i].ps;
      pop_ready  = vt[i].pr;
      clear_i    = vt[i].clr;
      tick();
      chk($sformatf("tbl%0d_valid", i), 64'(pop_valid), 64'(vt[i].ev));
      chk($sformatf("tbl%0d_ready", i), 64'(push_ready), 64'(vt[i].er));
      chk($sformatf("tbl%0d_occ", i), 64'(occupancy_o), 64'(vt[i].eo));
      if (vt[i].cd) begin
        chk($sformatf("tbl%0d_data", i), pop_data, vt[i].ed);
        chk($sformatf("tbl%0d_strb", i), 64'(pop_strb), 64'(vt[i].es));
      end
    end
    clear_i = 1'b0;

    // Streaming at full rate with alternating strobes.
    do_reset();
    pop_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      push_valid = 1'b1;
      push_data  = 64'(i);
      push_strb  = (i % 2 == 1) ? 8'h0F : 8'hF0;
      tick();
      chk($sformatf("stream%0d_valid", i), 64'(pop_valid), 64'd1);
      chk($sformatf("stream%0d_ready", i), 64'(push_ready), 64'd1);
      chk($sformatf("stream%0d_occ", i), 64'(occupancy_o), 64'd1);
      chk($sformatf("stream%0d_data", i), pop_data, 64'(i));
      chk($sformatf("stream%0d_strb", i), 64'(pop_strb),
          (i % 2 == 1) ? 64'h0F : 64'hF0);
    end
    push_valid = 1'b0;
    tick();
    chk("stream_end_occ", 64'(occupancy_o), 64'd0);

    // Randomized traffic against the reference model.
    do_reset();
    pushed = 0;
    cyc = 0;
    while (pushed < 10000 && cyc < 40000) begin
      push_valid = ($urandom_range(0, 3) != 0);
      push_data  = {$urandom, $urandom};
      push_strb  = 8'($urandom);
      pop_ready  = ($urandom_range(0, 3) != 0);
      clear_i    = ($urandom_range(0, 255) == 0);
      #1;
      // Ready/valid must not react to same-cycle input changes.
      chk("rnd_comb_ready", 64'(push_ready), 64'(mq.size() < 2));
      chk("rnd_comb_valid", 64'(pop_valid), 64'(mq.size() > 0));
      phs = push_valid && (mq.size() < 2) && !clear_i;
      if (phs) pushed++;
      tick();
      check_model("rnd");
      cyc++;
    end
    chk("rnd_beats_done", 64'(pushed >= 10000), 64'd1);
    push_valid = 1'b0;
    clear_i    = 1'b0;
    pop_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_model("drain");
    end
    chk("drain_empty", 64'(occupancy_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
